// File: rtl/instruction_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and
// writes them to instruction memory, holding the CPU in reset until done.
module instruction_loader #(
  parameter int MEM_WORDS = 101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Load_Start,
  input  logic [7:0]  Byte_In,
  input  logic        Byte_Valid,
  output logic        Byte_Ready,
  output logic        Mem_Write_En,
  output logic [31:0] Mem_Write_Address,
  output logic [31:0] Mem_Write_Data,
  output logic        Cpu_Hold,
  output logic        Load_Done,
  output logic        Load_Error
);

  typedef enum logic [2:0] {
    IDLE, COUNT_LO, COUNT_HI, DATA, FLUSH, DONE, ERROR
  } state_t;

  typedef struct packed {
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_req_t;

  state_t      state, state_nxt;
  wr_req_t     wr;
  logic [15:0] count, index;
  logic [1:0]  lane;
  logic [23:0] asm_q;
  logic        accept;
  logic        last_word;
  logic [15:0] count_full;

  assign accept     = Byte_Valid && Byte_Ready;
  assign count_full = {Byte_In, count[7:0]};
  assign last_word  = (index == count - 16'd1);

  always_comb begin
    state_nxt  = state;
    Byte_Ready = 1'b0;
    Cpu_Hold   = 1'b1;
    Load_Done  = 1'b0;
    Load_Error = 1'b0;
    case (state)
      IDLE:     if (Load_Start) state_nxt = COUNT_LO;
      COUNT_LO: begin
        Byte_Ready = 1'b1;
        if (accept) state_nxt = COUNT_HI;
      end
      COUNT_HI: begin
        Byte_Ready = 1'b1;
        if (accept) begin
          if (count_full == 16'd0)                  state_nxt = DONE;
          else if (count_full > 16'(MEM_WORDS))     state_nxt = ERROR;
          else                                      state_nxt = DATA;
        end
      end
      DATA: begin
        Byte_Ready = 1'b1;
        if (accept && lane == 2'd3 && last_word) state_nxt = FLUSH;
      end
      FLUSH:    state_nxt = DONE;
      DONE: begin
        Cpu_Hold  = 1'b0;
        Load_Done = 1'b1;
        if (Load_Start) state_nxt = COUNT_LO;
      end
      ERROR: begin
        Load_Error = 1'b1;
        if (Load_Start) state_nxt = COUNT_LO;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr    <= '0;
      count <= '0;
      index <= '0;
      lane  <= '0;
      asm_q <= '0;
    end else begin
      state  <= state_nxt;
      wr.en  <= 1'b0;
      if (state == COUNT_LO && accept) count[7:0] <= Byte_In;
      if (state == COUNT_HI && accept) begin
        count[15:8] <= Byte_In;
        index       <= '0;
        lane        <= '0;
      end
      if (state == DATA && accept) begin
        lane <= lane + 2'd1;
        case (lane)
          2'd0: asm_q[7:0]   <= Byte_In;
          2'd1: asm_q[15:8]  <= Byte_In;
          2'd2: asm_q[23:16] <= Byte_In;
          default: begin
            // Address/data hold until the next completed word.
            wr.en   <= 1'b1;
            wr.addr <= {16'b0, index[13:0], 2'b00};
            wr.data <= {Byte_In, asm_q};
            index   <= index + 16'd1;
          end
        endcase
      end
    end
  end

  assign Mem_Write_En      = wr.en;
  assign Mem_Write_Address = wr.addr;
  assign Mem_Write_Data    = wr.data;

endmodule

// File: tb/tb_instruction_loader.sv
// Scenario bench for instruction_loader: byte-stream driver, write monitor,
// expected writes derived from the word list (word i -> address 4*i).
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Load_Start = 1'b0;
  logic [7:0]  Byte_In = 8'h00;
  logic        Byte_Valid = 1'b0;
  logic        Byte_Ready, Mem_Write_En, Cpu_Hold, Load_Done, Load_Error;
  logic [31:0] Mem_Write_Address, Mem_Write_Data;

  instruction_loader #(.MEM_WORDS(101)) dut (
    .clk(clk), .rst(rst), .Load_Start(Load_Start), .Byte_In(Byte_In),
    .Byte_Valid(Byte_Valid), .Byte_Ready(Byte_Ready), .Mem_Write_En(Mem_Write_En),
    .Mem_Write_Address(Mem_Write_Address), .Mem_Write_Data(Mem_Write_Data),
    .Cpu_Hold(Cpu_Hold), .Load_Done(Load_Done), .Load_Error(Load_Error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          nb;
  } wr_t;

  wr_t         wq[$];
  int          nacc = 0;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  stim[$];
  logic [31:0] words[$];

  always @(posedge clk) if (Byte_Valid === 1'b1 && Byte_Ready === 1'b1) nacc++;
  always @(negedge clk) if (Mem_Write_En === 1'b1) wq.push_back('{Mem_Write_Address, Mem_Write_Data, nacc});

  task automatic build(input int cnt);
    logic [15:0] c;
    c = cnt[15:0];
    stim.delete();
    stim.push_back(c[7:0]);
    stim.push_back(c[15:8]);
    foreach (words[i]) for (int k = 0; k < 4; k++) stim.push_back(words[i][8*k +: 8]);
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  task automatic start();
    Load_Start = 1'b1;
    @(negedge clk);
    Load_Start = 1'b0;
  endtask

  // Returns at the negedge following the edge that accepted the byte.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      Byte_Valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    Byte_Valid = 1'b1;
    Byte_In    = b;
    n = 0;
    while (Byte_Ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL accept_timeout ready=%b want 1", Byte_Ready);
    end else @(negedge clk);
  endtask

  task automatic send_stream(input int gap, input bit rnd);
    foreach (stim[i]) send_byte(stim[i], rnd ? int'($urandom_range(0, gap)) : gap);
    Byte_Valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({Cpu_Hold, Byte_Ready, Mem_Write_En, Load_Done, Load_Error} !== 5'b10000) begin
      bad++; $display("FAIL reset_flags got %b want 10000",
        {Cpu_Hold, Byte_Ready, Mem_Write_En, Load_Done, Load_Error});
    end
    total++;
    if (Mem_Write_Address !== 32'h0 || Mem_Write_Data !== 32'h0) begin
      bad++; $display("FAIL reset_bus got %h/%h want 0/0", Mem_Write_Address, Mem_Write_Data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int wb, nb0;
    words = '{32'hE3A00014, 32'hE3A01A01};
    build(2);
    start();
    wb = wq.size(); nb0 = nacc;
    send_stream(0, 1'b0);
    total++;
    if ({Mem_Write_En, Cpu_Hold, Load_Done} !== 3'b110) begin
      bad++; $display("FAIL basic_flush en/hold/done got %b want 110", {Mem_Write_En, Cpu_Hold, Load_Done});
    end
    @(negedge clk);
    total++;
    if ({Mem_Write_En, Cpu_Hold, Load_Done} !== 3'b001) begin
      bad++; $display("FAIL basic_release en/hold/done got %b want 001", {Mem_Write_En, Cpu_Hold, Load_Done});
    end
    total++;
    if (wq.size() - wb !== 2) begin
      bad++; $display("FAIL basic_nwrites got %0d want 2", wq.size() - wb);
    end else for (int i = 0; i < 2; i++) begin
      total++;
      if (wq[wb+i].a !== 32'(i*4) || wq[wb+i].d !== words[i] || wq[wb+i].nb !== nb0 + 6 + 4*i) begin
        bad++; $display("FAIL basic_write%0d got %h/%h@%0d want %h/%h@%0d", i, wq[wb+i].a,
          wq[wb+i].d, wq[wb+i].nb - nb0, 32'(i*4), words[i], 6 + 4*i);
      end
    end
  endtask

  task automatic test_gapped();
    int wb, nb0;
    words = '{32'hE3A00014, 32'hE3A01A01};
    build(2);
    start();
    wb = wq.size(); nb0 = nacc;
    send_stream(3, 1'b0);
    @(negedge clk);
    total++;
    if (wq.size() - wb !== 2 || Load_Done !== 1'b1) begin
      bad++; $display("FAIL gap_nwrites got %0d done=%b want 2 done=1", wq.size() - wb, Load_Done);
    end else for (int i = 0; i < 2; i++) begin
      total++;
      if (wq[wb+i].a !== 32'(i*4) || wq[wb+i].d !== words[i] || wq[wb+i].nb !== nb0 + 6 + 4*i) begin
        bad++; $display("FAIL gap_write%0d got %h/%h@%0d want %h/%h@%0d", i, wq[wb+i].a,
          wq[wb+i].d, wq[wb+i].nb - nb0, 32'(i*4), words[i], 6 + 4*i);
      end
    end
  endtask

  task automatic test_zero();
    int wb;
    words.delete();
    build(0);
    start();
    wb = wq.size();
    send_stream(0, 1'b0);
    total++;
    if ({Load_Done, Cpu_Hold} !== 2'b10) begin
      bad++; $display("FAIL zero_done done/hold got %b want 10", {Load_Done, Cpu_Hold});
    end
    repeat (2) @(negedge clk);
    total++;
    if (wq.size() !== wb) begin
      bad++; $display("FAIL zero_nowrite got %0d writes want 0", wq.size() - wb);
    end
  endtask

  task automatic test_overflow();
    int wb, nb0;
    words.delete();
    build(102);
    start();
    wb = wq.size(); nb0 = nacc;
    send_stream(0, 1'b0);
    total++;
    if ({Load_Error, Byte_Ready, Cpu_Hold, Load_Done} !== 4'b1010) begin
      bad++; $display("FAIL ovf_state err/rdy/hold/done got %b want 1010",
        {Load_Error, Byte_Ready, Cpu_Hold, Load_Done});
    end
    Byte_Valid = 1'b1; Byte_In = 8'h55;
    repeat (3) @(negedge clk);
    Byte_Valid = 1'b0;
    total++;
    if (nacc !== nb0 + 2 || wq.size() !== wb || Load_Error !== 1'b1) begin
      bad++; $display("FAIL ovf_stuck got acc=%0d writes=%0d err=%b want 2/0/1",
        nacc - nb0, wq.size() - wb, Load_Error);
    end
    words = '{32'hEAFFFFFE};
    build(1);
    start();
    wb = wq.size();
    send_stream(0, 1'b0);
    @(negedge clk);
    total++;
    if (wq.size() - wb !== 1 || {Load_Done, Load_Error} !== 2'b10) begin
      bad++; $display("FAIL ovf_recover got writes=%0d done/err=%b want 1/10",
        wq.size() - wb, {Load_Done, Load_Error});
    end else begin
      total++;
      if (wq[wb].a !== 32'h0 || wq[wb].d !== 32'hEAFFFFFE) begin
        bad++; $display("FAIL ovf_word got %h/%h want 00000000/eafffffe", wq[wb].a, wq[wb].d);
      end
    end
  endtask

  task automatic test_full();
    int wb, errs;
    rand_words(101);
    build(101);
    start();
    wb = wq.size();
    send_stream(1, 1'b1);
    total++;
    if (Mem_Write_En !== 1'b1 || Mem_Write_Address !== 32'h190 || Load_Done !== 1'b0) begin
      bad++; $display("FAIL full_last got en=%b addr=%h done=%b want 1/190/0",
        Mem_Write_En, Mem_Write_Address, Load_Done);
    end
    @(negedge clk);
    total++;
    errs = 0;
    if (wq.size() - wb !== 101) errs = 1;
    else for (int i = 0; i < 101; i++)
      if (wq[wb+i].a !== 32'(i*4) || wq[wb+i].d !== words[i]) errs++;
    if (errs != 0 || Load_Done !== 1'b1) begin
      bad++; $display("FAIL full_writes got writes=%0d badwords=%0d done=%b want 101/0/1",
        wq.size() - wb, errs, Load_Done);
    end
  endtask

  task automatic test_random();
    int wb, n, errs;
    repeat (6) begin
      n = $urandom_range(1, 12);
      rand_words(n);
      build(n);
      start();
      wb = wq.size();
      send_stream(2, 1'b1);
      @(negedge clk);
      total++;
      errs = 0;
      if (wq.size() - wb !== n) errs = 1;
      else for (int i = 0; i < n; i++)
        if (wq[wb+i].a !== 32'(i*4) || wq[wb+i].d !== words[i]) errs++;
      if (errs != 0 || {Load_Done, Cpu_Hold} !== 2'b10) begin
        bad++; $display("FAIL rand_load n=%0d got writes=%0d badwords=%0d done/hold=%b want %0d/0/10",
          n, wq.size() - wb, errs, {Load_Done, Cpu_Hold}, n);
      end
    end
  endtask

  task automatic test_reset_mid();
    int wb;
    rand_words(3);
    build(3);
    start();
    wb = wq.size();
    for (int i = 0; i < 8; i++) send_byte(stim[i], 0);
    Byte_Valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({Cpu_Hold, Byte_Ready, Mem_Write_En, Load_Done, Load_Error} !== 5'b10000 ||
        Mem_Write_Address !== 32'h0 || Mem_Write_Data !== 32'h0) begin
      bad++; $display("FAIL midrst_values got %b %h/%h want 10000 0/0",
        {Cpu_Hold, Byte_Ready, Mem_Write_En, Load_Done, Load_Error}, Mem_Write_Address, Mem_Write_Data);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (wq.size() - wb !== 1) begin
      bad++; $display("FAIL midrst_nwrites got %0d want 1", wq.size() - wb);
    end else begin
      total++;
      if (wq[wb].a !== 32'h0 || wq[wb].d !== words[0]) begin
        bad++; $display("FAIL midrst_word0 got %h/%h want 0/%h", wq[wb].a, wq[wb].d, words[0]);
      end
    end
  endtask

  task automatic test_restart();
    int wb;
    rand_words(1);
    build(1);
    start();
    send_stream(0, 1'b0);
    @(negedge clk);
    Load_Start = 1'b1;
    @(negedge clk);
    Load_Start = 1'b0;
    total++;
    if ({Cpu_Hold, Load_Done, Byte_Ready} !== 3'b101) begin
      bad++; $display("FAIL restart_hold hold/done/rdy got %b want 101", {Cpu_Hold, Load_Done, Byte_Ready});
    end
    rand_words(2);
    build(2);
    wb = wq.size();
    send_stream(1, 1'b1);
    @(negedge clk);
    total++;
    if (wq.size() - wb !== 2 || Load_Done !== 1'b1) begin
      bad++; $display("FAIL restart_nwrites got %0d done=%b want 2/1", wq.size() - wb, Load_Done);
    end else for (int i = 0; i < 2; i++) begin
      total++;
      if (wq[wb+i].a !== 32'(i*4) || wq[wb+i].d !== words[i]) begin
        bad++; $display("FAIL restart_write%0d got %h/%h want %h/%h", i, wq[wb+i].a, wq[wb+i].d,
          32'(i*4), words[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_zero();
    test_overflow();
    test_full();
    test_random();
    test_reset_mid();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Boot-time writer for the instruction memory. Accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and issues one write per word into a writable instruction memory at byte addresses 0, 4, 8, … The memory indexes words by Address[31:2]. The block holds the processor in reset until a complete program has been written, then releases it to fetch from address 0.

## Interface
- MEM_WORDS, 101: capacity of the instruction memory in words; valid word indices are 0..MEM_WORDS-1.
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Load_Start  in  1  single-cycle request to begin a new load.
- Byte_In  in  8  stream byte.
- Byte_Valid  in  1  Byte_In is valid this cycle.
- Byte_Ready  out  1  the loader accepts a byte this cycle.
- Mem_Write_En  out  1  single-cycle write strobe to the instruction memory.
- Mem_Write_Address  out  32  byte address of the write (word index << 2).
- Mem_Write_Data  out  32  assembled instruction word.
- Cpu_Hold  out  1  holds the processor in reset while high.
- Load_Done  out  1  the program is fully written.
- Load_Error  out  1  the header word count exceeded MEM_WORDS.

## Operation
- **Stream format:** 16-bit word count N (low byte first), then N words, 4 bytes each, least-significant byte first.
- **Handshake:** a byte is accepted in any cycle where Byte_Valid && Byte_Ready. Byte_Ready is high only in COUNT_LO, COUNT_HI and DATA. Byte_In is ignored when not accepted.

States:
- **IDLE:** Cpu_Hold=1. Load_Start moves to COUNT_LO.
- **COUNT_LO:** an accepted byte sets count[7:0]; move to COUNT_HI.
- **COUNT_HI:** an accepted byte sets count[15:8]. The next state depends on the complete count:
  - count == 0: go to DONE.
  - count > MEM_WORDS: go to ERROR.
  - otherwise: go to DATA with word index 0 and byte lane 0.
- **DATA:**
  - An accepted byte is written into lane (the lane register) of the assembly register, and lane increments mod 4.
  - When lane 3 is accepted: the word is complete. Register Mem_Write_Data = {b3,b2,b1,b0} and Mem_Write_Address = index<<2, pulse Mem_Write_En the next cycle, then increment index.
  - When the completed word is word N-1, move to FLUSH.
  - Byte_Ready stays high during a write pulse, so full throughput is 1 byte per cycle.
- **FLUSH:** lasts one cycle, during which the final write pulse is on the bus. Then go to DONE.
- **DONE:** Load_Done=1, Cpu_Hold=0. Load_Start returns to COUNT_LO with Cpu_Hold=1 re-asserted.
- **ERROR:** Load_Error=1, Cpu_Hold=1, no writes. Only Load_Start (→ COUNT_LO) or rst leaves this state.

Other rules:
- Load_Start is ignored in COUNT_LO, COUNT_HI, DATA and FLUSH.
- The index counter is 16 bits. Because count ≤ MEM_WORDS, it never wraps during a legal load.
- Mem_Write_Address[31:16] and [1:0] are always 0.

## Timing
- **Reset values:** state IDLE, Cpu_Hold=1, Byte_Ready=0, Mem_Write_En=0, Mem_Write_Address=0, Mem_Write_Data=0, Load_Done=0, Load_Error=0. Count, index and lane clear to 0.
- **Write latency:** the 4th byte of a word is accepted at edge t; Mem_Write_En is high for exactly the cycle after t, with address and data stable in that cycle. Address and data hold their value until the next write.
- **Release:** the last byte is accepted at edge t; the write strobe is in the cycle after t (FLUSH); Load_Done=1 and Cpu_Hold=0 from the cycle after that. The processor therefore never leaves reset before the last write has been strobed.
- **Back-pressure-free:** Byte_Valid gaps of any length stall assembly without losing lane or index state.
- **Reset mid-load:** rst in any state returns to reset values on the same edge. No write strobe is issued for a partially assembled word.
- **Restart after DONE:** Load_Start at edge t gives Cpu_Hold=1 and Load_Done=0 from the cycle after t. Memory contents are not cleared; only the words in the new stream are overwritten.

## Test plan
- **Basic load:** rst, Load_Start, bytes 02 00, 14 00 A0 E3, 01 1A A0 E3, sent back-to-back.
  - Writes: (0x0, 0xE3A00014), then (0x4, 0xE3A01A01).
  - Load_Done=1 and Cpu_Hold=0 two cycles after the last byte.
- **Gapped stream:** same data as the basic load, with Byte_Valid low for 3 cycles between every byte. Required: identical writes, and no strobe until each word's 4th byte.
- **Zero count:** header 00 00. Required: DONE the cycle after COUNT_HI, no Mem_Write_En pulses.
- **Overflow:** header 66 00 (102 > 101). Required: Load_Error=1, Byte_Ready=0, Cpu_Hold=1, no writes. A following Load_Start with header 01 00 and word 0xEAFFFFFE then completes normally.
- **Full capacity:** header 65 00 (101) followed by 101 words. Required: the last write goes to address 0x190 and Load_Done asserts.
- **Reset and restart:**
  - rst after 2 bytes of word 1: all outputs return to reset values and no strobe is issued for word 1.
  - Load_Start in DONE reloads and re-asserts Cpu_Hold the next cycle.
